dram_spectrogram: RTL and testbench



---
 rtl/dram_spectrogram_pkg.sv | 15 +
 rtl/dram_spectrogram_if.sv | 24 ++
 rtl/dram_spectrogram_port.sv | 26 ++
 rtl/dram_spectrogram.sv | 59 +++++
 tb/tb_dram_spectrogram.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/dram_spectrogram_pkg.sv
// Shared sizing and collision-policy constants for the spectrogram bin buffer.
package dram_spectrogram_pkg;

  localparam int SPEC_ADDR_WIDTH = 9;
  localparam int SPEC_DATA_WIDTH = 10;
  localparam int SPEC_DEPTH      = 512;

  typedef enum logic {
    PORT_A_WINS = 1'b0,
    PORT_B_WINS = 1'b1
  } collision_e;

  localparam collision_e COLLISION_POLICY = PORT_A_WINS;

endpackage

// File: rtl/dram_spectrogram_if.sv
// Both RAM ports bundled; the master drives address/data/strobe, the RAM (slave) returns read data.
interface dram_spectrogram_if #(
  parameter int ADDR_WIDTH = dram_spectrogram_pkg::SPEC_ADDR_WIDTH,
  parameter int DATA_WIDTH = dram_spectrogram_pkg::SPEC_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wr_data;
  logic                  a_wr_en;
  logic [DATA_WIDTH-1:0] a_rd_data;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic                  b_wr_en;
  logic [DATA_WIDTH-1:0] b_rd_data;

  modport master (
    output a_addr, a_wr_data, a_wr_en, b_addr, b_wr_data, b_wr_en,
    input  a_rd_data, b_rd_data
  );

  modport slave (
    input  a_addr, a_wr_data, a_wr_en, b_addr, b_wr_data, b_wr_en,
    output a_rd_data, b_rd_data
  );
endinterface

// File: rtl/dram_spectrogram_port.sv
// Per-port registered read path: reset clears, a write cycle holds the previous word.
module dram_spectrogram_port #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] mem_word_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (!wr_en_i) rd_data_d = mem_word_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dram_spectrogram.sv
// 512 x 10 true dual-port RAM on a single clock; reads return pre-write contents, port A wins write collisions.
module dram_spectrogram
  import dram_spectrogram_pkg::*;
#(
  parameter int ADDR_WIDTH = SPEC_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPEC_DATA_WIDTH
) (
  input  logic              a_clk,
  input  logic              b_clk,
  input  logic              a_rst,
  input  logic              b_rst,
  dram_spectrogram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_word, b_word;
  logic                  a_we, b_we;
  logic                  unused_b_clk;

  // b_clk shares the a_clk net; it is a symmetry-only port.
  assign unused_b_clk = b_clk;

  always_comb begin
    a_we = bus.a_wr_en;
    b_we = bus.b_wr_en;
    if (bus.a_wr_en && bus.b_wr_en && (bus.a_addr == bus.b_addr)) begin
      if (COLLISION_POLICY == PORT_A_WINS) b_we = 1'b0;
      else                                 a_we = 1'b0;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_we) mem_q[bus.a_addr] <= bus.a_wr_data;
    if (b_we) mem_q[bus.b_addr] <= bus.b_wr_data;
  end

  // Sampled by the port registers on the same edge as the write, so reads see old data.
  assign a_word = mem_q[bus.a_addr];
  assign b_word = mem_q[bus.b_addr];

  dram_spectrogram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk_i      (a_clk),
    .rst_i      (a_rst),
    .wr_en_i    (bus.a_wr_en),
    .mem_word_i (a_word),
    .rd_data_o  (bus.a_rd_data)
  );

  dram_spectrogram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk_i      (a_clk),
    .rst_i      (b_rst),
    .wr_en_i    (bus.b_wr_en),
    .mem_word_i (b_word),
    .rd_data_o  (bus.b_rd_data)
  );

endmodule

// File: tb/tb_dram_spectrogram.sv
// Directed bench for dram_spectrogram: stimulus pushes expected read data, a monitor pops and compares.
module tb_dram_spectrogram;

  logic clk = 1'b0;
  logic a_rst, b_rst;

  always #5 clk = ~clk;

  dram_spectrogram_if bus ();

  dram_spectrogram dut (
    .a_clk (clk),
    .b_clk (clk),
    .a_rst (a_rst),
    .b_rst (b_rst),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    logic [9:0] exp;
    string      tag;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       we;
    logic [8:0] addr;
    logic [9:0] data;
  } op_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [9:0] la, lb;

  function automatic op_t op(input logic rst, input logic we, input int addr, input int data);
    op_t o;
    o.rst  = rst;
    o.we   = we;
    o.addr = addr[8:0];
    o.data = data[9:0];
    return o;
  endfunction

  task automatic push_a(input int v, input string tag);
    exp_t e;
    e.due = cyc + 1; e.exp = v[9:0]; e.tag = tag;
    qa.push_back(e);
    la = v[9:0];
  endtask

  task automatic push_b(input int v, input string tag);
    exp_t e;
    e.due = cyc + 1; e.exp = v[9:0]; e.tag = tag;
    qb.push_back(e);
    lb = v[9:0];
  endtask

  task automatic step(input op_t a, input op_t b);
    a_rst         = a.rst;
    bus.a_wr_en   = a.we;
    bus.a_addr    = a.addr;
    bus.a_wr_data = a.data;
    b_rst         = b.rst;
    bus.b_wr_en   = b.we;
    bus.b_addr    = b.addr;
    bus.b_wr_data = b.data;
    @(negedge clk);
  endtask

  task automatic compare(input string tag, input logic [9:0] act, input logic [9:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // Monitor: data is registered on the edge, so sample 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        compare(e.tag, bus.a_rd_data, e.exp);
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        compare(e.tag, bus.b_rd_data, e.exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active at cyc %0d, expected completion", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    bus.a_wr_en = 1'b1; bus.a_addr = '0; bus.a_wr_data = '0;
    bus.b_wr_en = 1'b1; bus.b_addr = 9'd511; bus.b_wr_data = 10'd512;
    @(negedge clk);

    // Port A reset held while B writes
    for (int i = 0; i < 20; i++) begin
      push_a(0, "a_rst_held");
      step(op(1, 0, 0, 0), op(0, 1, 511, 512));
    end
    // Port B reset held; A released but only writes, so it keeps 0
    for (int i = 0; i < 20; i++) begin
      push_a(0, "a_after_rst");
      push_b(0, "b_rst_held");
      step(op(0, 1, i, 1023 - i), op(1, 0, 0, 0));
    end
    for (int i = 20; i < 23; i++) begin
      push_a(0, "a_after_rst");
      push_b(0, "b_after_rst");
      step(op(0, 1, i, 1023 - i), op(0, 1, 400 + i, 623 - i));
    end

    // Port A round trip
    for (int k = 0; k < 512; k++) step(op(0, 1, k, 1023 - k), op(0, 0, k, 0));
    for (int k = 0; k < 512; k++) begin
      push_a(1023 - k, "a_roundtrip");
      push_b(512 + k, "b_read_rev");
      step(op(0, 0, k, 0), op(0, 0, 511 - k, 0));
    end
    for (int k = 0; k < 512; k++) begin
      push_b(1023 - k, "b_cross_read");
      push_a(512 + k, "a_read_rev");
      step(op(0, 0, 511 - k, 0), op(0, 0, k, 0));
    end

    // B writes pattern k while A reads the same address (old data), then A reads it back
    for (int k = 0; k < 512; k++) begin
      push_a(1023 - k, "a_old_during_b_wr");
      push_b(lb, "b_hold_on_wr");
      step(op(0, 0, k, 0), op(0, 1, k, k));
    end
    for (int k = 0; k < 512; k++) begin
      push_a(k, "a_read_b_written");
      push_b(511 - k, "b_read_own");
      step(op(0, 0, k, 0), op(0, 0, 511 - k, 0));
    end
    for (int k = 0; k < 512; k++) begin
      push_a(k, "a_old_during_b_wr2");
      step(op(0, 0, k, 0), op(0, 1, k, 1023 - k));
    end

    // NORMAL_WRITE hold on both ports
    push_a(1018, "a_read5");           push_b(1017, "b_read6");
    step(op(0, 0, 5, 0), op(0, 0, 6, 0));
    push_a(1018, "a_hold_wr5");        push_b(1017, "b_hold_wr6");
    step(op(0, 1, 5, 'h155), op(0, 1, 6, 'h0F0));
    push_a('h155, "a_read5_new");      push_b('h0F0, "b_read6_new");
    step(op(0, 0, 5, 0), op(0, 0, 6, 0));

    // Cross-port collision: B reads old contents while A writes
    push_a('h155, "a_hold_wr7");       push_b(1016, "b_old_on_coll");
    step(op(0, 1, 7, 'h2AA), op(0, 0, 7, 0));
    push_a('h2AA, "a_read7");          push_b('h2AA, "b_read7");
    step(op(0, 0, 7, 0), op(0, 0, 7, 0));
    // Write-write collision: port A wins
    push_a('h2AA, "a_hold_ww9");       push_b('h2AA, "b_hold_ww9");
    step(op(0, 1, 9, 'h001), op(0, 1, 9, 'h3FF));
    push_a('h001, "a_read9_a_wins");   push_b('h001, "b_read9_a_wins");
    step(op(0, 0, 9, 0), op(0, 0, 9, 0));

    // Reset mid-stream on B only
    for (int i = 0; i < 20; i++) begin
      push_a(823 - i, "a_unaffected");
      push_b((i == 10) ? 0 : 923 - i, (i == 10) ? "b_rst_mid" : "b_burst");
      step(op(0, 0, 200 + i, 0), op(i == 10, 0, 100 + i, 0));
    end
    // Reset does not block a write
    push_a(723, "a_old_during_rst_wr"); push_b(0, "b_rst_with_wr");
    step(op(0, 0, 300, 0), op(1, 1, 300, 'h123));
    push_a('h123, "a_read_rst_wr");     push_b(923, "b_read_after_rst");
    step(op(0, 0, 300, 0), op(0, 0, 100, 0));
    for (int i = 0; i < 20; i++) begin
      push_b(923 - i, "b_intact");
      step(op(0, 1, 300, 'h123), op(0, 0, 100 + i, 0));
    end

    step(op(0, 1, 300, 'h123), op(0, 1, 301, 722));
    step(op(0, 1, 300, 'h123), op(0, 1, 301, 722));
    n_run++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending a=%0d b=%0d, expected 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
